// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one line memory port between I-cache and D-cache; a request seen in IDLE drives mem_* next cycle, one idle RELEASE cycle follows each mem_resp.
// Losers hold their level request until served. CACHE_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise the D-cache has fixed priority.
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [LINE_W-1:0] wdata_q, wdata_nxt;
  logic              write_q, write_nxt;
  logic              i_req, d_req, pick_d, d_is_write, granted;

  assign i_req = i_read;
  assign d_req = d_read | d_write;
  // A simultaneous read+write from the D-cache is issued as a read.
  assign d_is_write = d_write & ~d_read;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_nxt;

  assign pick_d = d_req & (~i_req | ~last_d_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_nxt;
    end
  end
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      write_q <= write_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    write_nxt = write_q;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    last_d_nxt = last_d_q;
`endif
    case (state)
      IDLE: begin
        if (pick_d) begin
          state_nxt = GRANT_D;
          addr_nxt  = d_addr;
          write_nxt = d_is_write;
          if (d_is_write) begin
            wdata_nxt = d_wdata;
          end
`ifdef CACHE_ARB_ROUND_ROBIN_EN
          last_d_nxt = 1'b1;
`endif
        end else if (i_req) begin
          state_nxt = GRANT_I;
          addr_nxt  = i_addr;
          write_nxt = 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
          last_d_nxt = 1'b0;
`endif
        end
      end
      GRANT_I: begin
        if (mem_resp) begin
          i_resp    = 1'b1;
          state_nxt = RELEASE;
        end
      end
      GRANT_D: begin
        if (mem_resp) begin
          d_resp    = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Strobes decode registered state only, so reset drops them without waiting for a clock.
  assign granted   = (state == GRANT_I) | (state == GRANT_D);
  assign mem_read  = granted & ~write_q;
  assign mem_write = granted & write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single line-granularity memory port (the cacheline adaptor's LLC-side interface) between the instruction cache and the data cache.
- Accepts whole-line read requests from the I-cache and read/write requests from the D-cache.
- Grants one requester at a time, latches its address and write data, and sequences the downstream request/response handshake.
- Routes the response back to the granted requester and inserts the idle cycle the downstream port needs between transactions.

Parameters:
- LINE_W, 256, cache line width in bits
- ADDR_W, 32, byte address width

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- i_read  input  1  I-cache line read request; level, held until i_resp
- i_addr  input  ADDR_W  I-cache line address
- i_rdata  output  LINE_W  line returned to I-cache
- i_resp  output  1  one-cycle completion pulse to I-cache
- d_read  input  1  D-cache line read request; level, held until d_resp
- d_write  input  1  D-cache line writeback request; level, held until d_resp
- d_addr  input  ADDR_W  D-cache line address
- d_wdata  input  LINE_W  D-cache writeback line
- d_rdata  output  LINE_W  line returned to D-cache
- d_resp  output  1  one-cycle completion pulse to D-cache
- mem_read  output  1  read request to line memory port
- mem_write  output  1  write request to line memory port
- mem_addr  output  ADDR_W  latched request address
- mem_wdata  output  LINE_W  latched write line
- mem_rdata  input  LINE_W  line from memory port, valid when mem_resp=1
- mem_resp  input  1  one-cycle completion from memory port

Behaviour:
- Connection is one clock, one reset: clk and reset only. reset is asynchronous and active-high.
- FSM states: IDLE, GRANT_I, GRANT_D, RELEASE.
- Reset forces IDLE from any state, including mid-transaction. Latched address and data are cleared to 0. All outputs read 0.
  - mem_read=mem_write=0, i_resp=d_resp=0, mem_addr=0, mem_wdata=0.
  - An in-flight downstream burst is abandoned; the memory port is reset alongside.
- IDLE arbitration:
  - If any request is pending, latch the winner's address into mem_addr.
  - For a D-cache write, also latch d_wdata into mem_wdata.
  - Latch the operation (read or write) and go to GRANT_I or GRANT_D.
  - With no request, stay in IDLE.
- Winner selection:
  - Without the macro: D-cache wins over the I-cache when both request.
  - If d_read and d_write are both 1, read takes precedence, matching the downstream port.
- GRANT_x:
  - mem_read or mem_write is driven from registered state.
  - Latched outputs are stable for the whole transaction; requester input changes are ignored.
  - On mem_resp=1, the granted requester's x_resp is 1 in the same cycle (combinational), and the FSM goes to RELEASE.
  - mem_read and mem_write stay asserted in the mem_resp cycle; the memory port ignores them while finishing.
- RELEASE: exactly one cycle with mem_read=mem_write=0, so the memory port returns to idle without re-triggering. Then go to IDLE.
- Latency:
  - A request seen in IDLE at cycle N drives mem_read/mem_write at N+1.
  - After mem_resp at cycle M, the next grant request appears no earlier than M+3.
- Read data path:
  - i_rdata and d_rdata both carry mem_rdata combinationally.
  - Data is meaningful only in the cycle the matching x_resp=1.
- Ungranted requesters: x_resp stays 0; requests are held and served later.
- mem_resp while in IDLE or RELEASE is ignored; no x_resp is generated.

Optional Feature:
- Macro: CACHE_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-granted pointer, reset to I-cache, so the D-cache wins the first tie.
  - On a tie in IDLE, the requester not granted last wins.
  - The pointer updates on every grant.
- Undefined:
  - Fixed D-cache priority; no pointer register.
  - A continuously requesting D-cache can starve the I-cache; this is accepted.

Test Plan:
- I-cache read alone: i_read=1, i_addr=0x0000_1040; memory returns 0xAA..AA after 4 cycles.
  - mem_read=1 with mem_addr=0x0000_1040 from the cycle after the request.
  - i_resp=1 for 1 cycle with i_rdata=0xAA..AA; d_resp stays 0.
  - mem_read=0 in the following RELEASE cycle.
- D-cache writeback: d_write=1, d_addr=0x0000_2000, d_wdata=0x0123..EF.
  - mem_write=1 with that address and data.
  - d_wdata is changed to 0 mid-transaction; mem_wdata must stay 0x0123..EF.
  - d_resp pulses once.
- Simultaneous requests, macro off: i_read and d_read asserted in the same cycle.
  - D-cache served first, then RELEASE, IDLE, then the I-cache.
  - Two mem_read windows separated by ≥2 idle cycles.
- Simultaneous back-to-back, macro on: both requesting continuously.
  - Grants alternate D, I, D, I.
  - I-cache never waits more than one D transaction.
- Reset mid-transaction: assert reset during GRANT_D before mem_resp.
  - mem_read/mem_write go to 0 asynchronously, before the next clk edge; x_resp=0.
  - After deassert, a new i_read is granted normally.
- d_read=d_write=1 together: read issued (mem_read=1, mem_write=0).
  - mem_resp arriving in IDLE produces no x_resp.
